// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXECUTE/MEM/WB phases,
// decodes the instruction word into datapath selects and owns the data-bus handshake.
// Optional feature: define CU_ILLEGAL_TRAP_EN to trap on unknown opcodes (TRAP state,
// illegal = 1) instead of skipping them with a PC update in DECODE.
module multicycle_control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrCode,
    input  logic        busReady,
    output logic        PCEn,
    output logic        regFileWe,
    output logic        aluSrcMuxSel,
    output logic [3:0]  aluControl,
    output logic [2:0]  RFWDSrcMuxSel,
    output logic        branch,
    output logic        jal,
    output logic        jalr,
    output logic        busWe,
    output logic        busRe,
    output logic [2:0]  busFunct3,
    output logic        illegal
);

    localparam logic [6:0] OpR  = 7'b0110011;
    localparam logic [6:0] OpI  = 7'b0010011;
    localparam logic [6:0] OpL  = 7'b0000011;
    localparam logic [6:0] OpS  = 7'b0100011;
    localparam logic [6:0] OpB  = 7'b1100011;
    localparam logic [6:0] OpLu = 7'b0110111;
    localparam logic [6:0] OpAu = 7'b0010111;
    localparam logic [6:0] OpJ  = 7'b1101111;
    localparam logic [6:0] OpJl = 7'b1100111;

`ifdef CU_ILLEGAL_TRAP_EN
    typedef enum logic [3:0] {
        StFetch, StDecode, StRExe, StIExe, StLuExe, StAuExe, StJExe, StBExe,
        StBPc, StLExe, StLMem, StLWb, StSExe, StSMem, StTrap
    } state_e;
`else
    typedef enum logic [3:0] {
        StFetch, StDecode, StRExe, StIExe, StLuExe, StAuExe, StJExe, StBExe,
        StBPc, StLExe, StLMem, StLWb, StSExe, StSMem
    } state_e;
`endif

    state_e state_q, state_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_r, is_i, is_l, is_s, is_b, is_lu, is_au, is_j, is_jl, is_known;
    logic [3:0] alu_ctrl_dec;
    logic       alu_src_dec;
    logic [2:0] wd_src_dec;
    logic       unused_instr;

    assign opcode   = instrCode[6:0];
    assign funct3   = instrCode[14:12];
    assign is_r     = (opcode == OpR);
    assign is_i     = (opcode == OpI);
    assign is_l     = (opcode == OpL);
    assign is_s     = (opcode == OpS);
    assign is_b     = (opcode == OpB);
    assign is_lu    = (opcode == OpLu);
    assign is_au    = (opcode == OpAu);
    assign is_j     = (opcode == OpJ);
    assign is_jl    = (opcode == OpJl);
    assign is_known = is_r | is_i | is_l | is_s | is_b | is_lu | is_au | is_j | is_jl;

    // Only SRAI among I-type ops takes instr[30]; L/S/JL and the rest default to ADD.
    assign alu_ctrl_dec = is_r ? {instrCode[30], funct3} :
                          is_i ? ((funct3 == 3'b101) ? {instrCode[30], funct3} : {1'b0, funct3}) :
                          is_b ? {1'b0, funct3} : 4'b0000;
    assign alu_src_dec  = is_i | is_l | is_s;
    assign wd_src_dec   = is_l             ? 3'd1 :
                          is_lu            ? 3'd2 :
                          is_au            ? 3'd3 :
                          (is_j | is_jl)   ? 3'd4 : 3'd0;

    assign unused_instr = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

    // State register; async reset forces FETCH so all outputs drop immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d       = state_q;
        PCEn          = 1'b0;
        regFileWe     = 1'b0;
        aluSrcMuxSel  = 1'b0;
        aluControl    = 4'b0000;
        RFWDSrcMuxSel = 3'd0;
        branch        = 1'b0;
        jal           = 1'b0;
        jalr          = 1'b0;
        busWe         = 1'b0;
        busRe         = 1'b0;
        busFunct3     = 3'b000;
        illegal       = 1'b0;

        // Datapath selects follow the held instruction from DECODE until the final state.
        if (state_q != StFetch
`ifdef CU_ILLEGAL_TRAP_EN
            && state_q != StTrap
`endif
            && is_known) begin
            aluSrcMuxSel  = alu_src_dec;
            aluControl    = alu_ctrl_dec;
            RFWDSrcMuxSel = wd_src_dec;
            busFunct3     = funct3;
            jal           = is_j | is_jl;
            jalr          = is_jl;
        end

        case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                if (is_r)                state_d = StRExe;
                else if (is_i)           state_d = StIExe;
                else if (is_l)           state_d = StLExe;
                else if (is_s)           state_d = StSExe;
                else if (is_b)           state_d = StBExe;
                else if (is_lu)          state_d = StLuExe;
                else if (is_au)          state_d = StAuExe;
                else if (is_j || is_jl)  state_d = StJExe;
                else begin
`ifdef CU_ILLEGAL_TRAP_EN
                    state_d = StTrap;
`else
                    PCEn    = 1'b1;
                    state_d = StFetch;
`endif
                end
            end
            StRExe, StIExe, StLuExe, StAuExe, StJExe: begin
                regFileWe = 1'b1;
                PCEn      = 1'b1;
                state_d   = StFetch;
            end
            StBExe: begin
                branch  = 1'b1;
                state_d = StBPc;
            end
            StBPc: begin
                branch  = 1'b1;
                PCEn    = 1'b1;
                state_d = StFetch;
            end
            StLExe: state_d = StLMem;
            StLMem: begin
                busRe = 1'b1;
                if (busReady) state_d = StLWb;
            end
            StLWb: begin
                regFileWe = 1'b1;
                PCEn      = 1'b1;
                state_d   = StFetch;
            end
            StSExe: state_d = StSMem;
            StSMem: begin
                busWe = 1'b1;
                if (busReady) begin
                    PCEn    = 1'b1;
                    state_d = StFetch;
                end
            end
`ifdef CU_ILLEGAL_TRAP_EN
            StTrap: illegal = 1'b1;
`endif
            default: state_d = StFetch;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized self-checking bench for multicycle_control_unit. The reference model
// derives each instruction's cycle-by-cycle control pattern from its class and the
// number of bus wait states using cycle-index arithmetic.
module tb_multicycle_control_unit;

    logic        clk;
    logic        reset;
    logic [31:0] instrCode;
    logic        busReady;
    logic        PCEn, regFileWe, aluSrcMuxSel, branch, jal, jalr, busWe, busRe, illegal;
    logic [3:0]  aluControl;
    logic [2:0]  RFWDSrcMuxSel, busFunct3;
    logic [18:0] outs;

    int tests_run;
    int tests_failed;

    multicycle_control_unit dut (
        .clk           (clk),
        .reset         (reset),
        .instrCode     (instrCode),
        .busReady      (busReady),
        .PCEn          (PCEn),
        .regFileWe     (regFileWe),
        .aluSrcMuxSel  (aluSrcMuxSel),
        .aluControl    (aluControl),
        .RFWDSrcMuxSel (RFWDSrcMuxSel),
        .branch        (branch),
        .jal           (jal),
        .jalr          (jalr),
        .busWe         (busWe),
        .busRe         (busRe),
        .busFunct3     (busFunct3),
        .illegal       (illegal)
    );

    assign outs = {PCEn, regFileWe, aluSrcMuxSel, aluControl, RFWDSrcMuxSel, branch, jal,
                   jalr, busWe, busRe, busFunct3, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (instr 0x%08h, t=%0t)",
                     tag, got, exp, instrCode, $time);
        end
    endtask

    function automatic logic [6:0] pick_opcode(input int cls);
        logic [6:0] op;
        case (cls)
            0: op = 7'b0110011;
            1: op = 7'b0010011;
            2: op = 7'b0000011;
            3: op = 7'b0100011;
            4: op = 7'b1100011;
            5: op = 7'b0110111;
            6: op = 7'b0010111;
            7: op = 7'b1101111;
            8: op = 7'b1100111;
            default: begin
                op = 7'($urandom_range(0, 127));
                while (op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
                       op == 7'b0100011 || op == 7'b1100011 || op == 7'b0110111 ||
                       op == 7'b0010111 || op == 7'b1101111 || op == 7'b1100111)
                    op = 7'($urandom_range(0, 127));
            end
        endcase
        return op;
    endfunction

    task automatic apply_reset();
        reset = 1'b0;
        #1 check("reset_outs", 32'(outs), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Entry: just after a rising edge with the DUT in FETCH. w = bus wait states (L/S).
    task automatic run_instr(input logic [31:0] instr, input int w);
        logic [6:0] op;
        logic [2:0] f3;
        logic       is_r, is_i, is_l, is_s, is_b, is_lu, is_au, is_j, is_jl, known, writes;
        logic       in_mem;
        logic [3:0] exp_alu;
        logic [2:0] exp_wd;
        int         n;
        op     = instr[6:0];
        f3     = instr[14:12];
        is_r   = (op == 7'b0110011);
        is_i   = (op == 7'b0010011);
        is_l   = (op == 7'b0000011);
        is_s   = (op == 7'b0100011);
        is_b   = (op == 7'b1100011);
        is_lu  = (op == 7'b0110111);
        is_au  = (op == 7'b0010111);
        is_j   = (op == 7'b1101111);
        is_jl  = (op == 7'b1100111);
        known  = is_r | is_i | is_l | is_s | is_b | is_lu | is_au | is_j | is_jl;
        writes = is_r | is_i | is_l | is_lu | is_au | is_j | is_jl;
        if (is_r)                   exp_alu = {instr[30], f3};
        else if (is_i && f3 == 3'b101) exp_alu = {instr[30], f3};
        else if (is_i || is_b)      exp_alu = {1'b0, f3};
        else                        exp_alu = 4'b0000;
        exp_wd = is_l ? 3'd1 : is_lu ? 3'd2 : is_au ? 3'd3 : (is_j || is_jl) ? 3'd4 : 3'd0;
        if (!known)     n = 2;
        else if (is_b)  n = 4;
        else if (is_s)  n = 4 + w;
        else if (is_l)  n = 5 + w;
        else            n = 3;
        instrCode = instr;

`ifdef CU_ILLEGAL_TRAP_EN
        if (!known) begin
            busReady = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("trap_fetch", 32'(outs), 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            check("trap_decode_pcen", 32'(PCEn), 32'd0);
            check("trap_decode_illegal", 32'(illegal), 32'd0);
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                busReady = 1'($urandom_range(0, 1));
                @(negedge clk);
                check("trap_outs", 32'(outs), 32'd1);
            end
            apply_reset();
            return;
        end
`endif

        for (int i = 0; i < n; i++) begin
            in_mem = (is_l || is_s) && (i >= 3) && (i <= 3 + w);
            if (in_mem) busReady = (i == 3 + w);
            else        busReady = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (i == 0) begin
                check("fetch_idle", 32'(outs), 32'd0);
            end else begin
                check("PCEn", 32'(PCEn), 32'(i == n - 1));
                check("regFileWe", 32'(regFileWe), 32'((i == n - 1) && writes));
                check("busRe", 32'(busRe), 32'(is_l && in_mem));
                check("busWe", 32'(busWe), 32'(is_s && in_mem));
                check("branch", 32'(branch), 32'(is_b && i >= 2));
                check("jal", 32'(jal), 32'(is_j || is_jl));
                check("jalr", 32'(jalr), 32'(is_jl));
                check("illegal", 32'(illegal), 32'd0);
                if (i == 2 && (is_r || is_i || is_l || is_s || is_b || is_jl))
                    check("aluControl", 32'(aluControl), 32'(exp_alu));
                if (i == 2 && (is_r || is_i || is_l || is_s || is_b))
                    check("aluSrcMuxSel", 32'(aluSrcMuxSel), 32'(is_i || is_l || is_s));
                if (in_mem)
                    check("busFunct3", 32'(busFunct3), 32'(f3));
                if (i == n - 1 && writes)
                    check("RFWDSrcMuxSel", 32'(RFWDSrcMuxSel), 32'(exp_wd));
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        instrCode    = 32'h0;
        busReady     = 1'b0;
        #1 check("reset_outs", 32'(outs), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        check("idle_after_reset", 32'(outs), 32'd0);

        run_instr(32'h002081B3, 0);  // ADD x3,x1,x2
        run_instr(32'h0040A283, 2);  // LW x5,4(x1), two wait states
        run_instr(32'h0020A423, 0);  // SW x2,8(x1)
        run_instr(32'h00209463, 0);  // BNE x1,x2,+8
        run_instr(32'h000280E7, 0);  // JALR x1,0(x5)
        run_instr(32'h4020D193, 0);  // SRAI: I-type funct3 101 with instr[30]
        run_instr(32'h0000007F, 0);  // unknown opcode

        // Reset asserted mid-S_MEM while the bus is stalled.
        instrCode = 32'h0020A423;
        busReady  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("smem_busWe", 32'(busWe), 32'd1);
        #2 reset = 1'b0;
        #1 check("rst_busWe_async", 32'(busWe), 32'd0);
        check("rst_outs", 32'(outs), 32'd0);
        @(posedge clk);
        #1 check("rst_hold", 32'(outs), 32'd0);
        reset = 1'b1;
        #1 check("post_rst_fetch", 32'(outs), 32'd0);
        run_instr(32'h0020A423, 1);

        for (int t = 0; t < 250; t++) begin
            logic [31:0] r;
            int          cls;
            r   = $urandom;
            cls = $urandom_range(0, 9);
            run_instr({r[31:7], pick_opcode(cls)}, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- FSM controller that sequences the RV32I multi-cycle datapath through FETCH, DECODE, EXECUTE, MEM and WB phases.
- Decodes the fetched instruction word and drives all datapath select/enable lines: PC enable, register-file write, ALU source/op, write-back mux, branch/jal/jalr.
- Owns the data-bus handshake for loads and stores, including wait states via busReady.

Parameters:
- none (the ISA encodings below are fixed)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- instrCode  in  32  current instruction word from ROM
- busReady  in  1  data-bus access completes this cycle
- PCEn  out  1  PC register load enable
- regFileWe  out  1  register-file write enable
- aluSrcMuxSel  out  1  0 = RD2, 1 = immediate
- aluControl  out  4  ALU op / branch compare select
- RFWDSrcMuxSel  out  3  0 = ALU, 1 = mem data, 2 = imm, 3 = PC+imm, 4 = PC+4
- branch  out  1  conditional-branch qualifier for the PC mux
- jal  out  1  force PC+imm into the PC mux
- jalr  out  1  select RD1 as the base for the PC+imm adder
- busWe  out  1  data-bus write strobe
- busRe  out  1  data-bus read strobe
- busFunct3  out  3  access size/sign, equal to instrCode[14:12]
- illegal  out  1  illegal-opcode flag (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (reset = 0, async): state = FETCH; every output = 0.
- Opcodes:
  - R = 0110011
  - I = 0010011
  - L = 0000011
  - S = 0100011
  - B = 1100011
  - LU = 0110111
  - AU = 0010111
  - J = 1101111
  - JL = 1100111
- aluControl:
  - R-type: {instr[30], funct3}.
  - I-type: {1'b0, funct3}, except funct3 = 101 gives {instr[30], 101}.
  - B-type: {1'b0, funct3}.
  - L/S/JL: 0000 (ADD).
  - Resulting ALU codes: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- Decoded control outputs (aluSrcMuxSel, aluControl, RFWDSrcMuxSel, branch, jal, jalr, busFunct3) are combinational from state + instrCode and are 0 in FETCH.
- jal/jalr are held from DECODE through the final state; branch is held from B_EXE through B_PC. The registered next-PC then holds the target when PCEn fires.
- States and transitions:
  - FETCH -> DECODE (1 cycle).
  - DECODE: R -> R_EXE, I -> I_EXE, L -> L_EXE, S -> S_EXE, B -> B_EXE, LU -> LU_EXE, AU -> AU_EXE, J and JL -> J_EXE.
  - Unknown opcode -> FETCH with PCEn = 1 in DECODE (skip), or TRAP with the optional feature.
  - R_EXE / I_EXE: regFileWe = 1, RFWDSrcMuxSel = 0, PCEn = 1 -> FETCH. aluSrcMuxSel = 0 (R) or 1 (I).
  - LU_EXE: RFWDSrcMuxSel = 2; AU_EXE: RFWDSrcMuxSel = 3. Both assert regFileWe and PCEn -> FETCH.
  - J_EXE: regFileWe = 1, RFWDSrcMuxSel = 4, PCEn = 1, jal = 1; jalr = 1 additionally for JL -> FETCH.
  - B_EXE: aluSrcMuxSel = 0, branch = 1 -> B_PC. B_PC: branch = 1, PCEn = 1 -> FETCH.
  - L_EXE: aluSrcMuxSel = 1 -> L_MEM. L_MEM: busRe = 1; stay while busReady = 0; -> L_WB when busReady = 1. L_WB: regFileWe = 1, RFWDSrcMuxSel = 1, PCEn = 1 -> FETCH.
  - S_EXE: aluSrcMuxSel = 1 -> S_MEM. S_MEM: busWe = 1; stay while busReady = 0; when busReady = 1, PCEn = 1 -> FETCH.
- Cycle counts with zero wait states:
  - R/I/LU/AU/J/JL: 3
  - B: 4
  - S: 4
  - L: 5
  - Each busReady-low cycle adds one.
- At most one PCEn pulse and at most one regFileWe pulse per instruction.
- busWe and busRe are never both high.
- busReady is ignored outside L_MEM/S_MEM.
- Reset during L_MEM/S_MEM: busRe/busWe drop asynchronously and no write-back or PC update occurs.

Optional Feature:
- Macro: CU_ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE -> TRAP. TRAP is terminal until reset and asserts illegal = 1, with all other outputs 0 and no PCEn.
- Undefined: the unknown opcode is skipped with PCEn = 1 in DECODE; illegal tied 0; TRAP state absent.

Test Plan:
- Reset low mid-S_MEM with busReady = 0 -> busWe = 0 immediately; after release, state FETCH with all outputs 0.
- ADD x3,x1,x2 (0x002081B3) -> R_EXE on cycle 3: aluControl = 0000, regFileWe = 1, RFWDSrcMuxSel = 0, PCEn = 1; back to FETCH.
- LW x5,4(x1) (0x0040A283) with busReady low 2 cycles -> busRe high 3 cycles, then L_WB with RFWDSrcMuxSel = 1, regFileWe = 1; 7 cycles total.
- SW x2,8(x1) (0x0020A423) with busReady = 1 -> S_MEM busWe = 1, busFunct3 = 010, PCEn = 1; regFileWe never asserted.
- BNE x1,x2,+8 (0x00209463) -> B_EXE/B_PC: aluControl[2:0] = 001, branch = 1; PCEn only in B_PC; 4 cycles.
- JALR x1,0(x5) (0x000280E7) -> jalr = 1 and jal = 1 in DECODE/J_EXE, RFWDSrcMuxSel = 4.
- Opcode 0x7F -> TRAP with illegal = 1 (macro defined), or skip with PCEn = 1 in DECODE (undefined).
